// File: rtl/ula_pkg.sv
// Shared constants for the ULA block: sequencer stage encodings and default widths
// used by the sequencer, storage registers and the ULA itself.
package ula_pkg;
  localparam int STAGE_W    = 3;
  localparam int ULA_DATA_W = 4;
  localparam int ULA_OP_W   = 3;

  typedef enum logic [STAGE_W-1:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } ula_stage_e;
endpackage

// File: rtl/ula_enter_conditioner.sv
// Enter button conditioning: 2-flop synchronizer, optional debounce, rising-edge pulse.
// Debounce counter is built only when ULA_DEBOUNCE_EN is defined.
module ula_enter_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic enter,
  output logic enter_pulse
);
  logic sync1, sync2, level, prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= enter;
      sync2 <= sync1;
    end
  end

`ifdef ULA_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             deb;

  // Level flips only after sync2 disagrees for DEBOUNCE_CYCLES samples in a row.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync2 == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt <= '0;
      deb <= sync2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign level = deb;
`else
  assign level = sync2;
`endif

  always_ff @(posedge clock) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign enter_pulse = level & ~prev;
endmodule

// File: rtl/ula_input_sequencer.sv
// Captures operand A, operand B and opcode from a shared switch bus on successive
// enter presses, then fires one execute pulse. Optional debounce: ULA_DEBOUNCE_EN.
module ula_input_sequencer
  import ula_pkg::*;
#(
  parameter int DATA_W          = ULA_DATA_W,
  parameter int OP_W            = ULA_OP_W,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               enter,
  input  logic               clear,
  output logic [DATA_W-1:0]  operand_a,
  output logic [DATA_W-1:0]  operand_b,
  output logic [OP_W-1:0]    opcode,
  output logic               load_a,
  output logic               load_b,
  output logic               load_op,
  output logic               execute,
  output logic [STAGE_W-1:0] stage
);
  logic       enter_pulse;
  ula_stage_e state_q, state_d;
  logic       cap_a, cap_b, cap_op, exec_d;

  ula_enter_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clock       (clock),
    .reset       (reset),
    .enter       (enter),
    .enter_pulse (enter_pulse)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= WAIT_A;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = WAIT_A;
    end else begin
      case (state_q)
        WAIT_A:  if (enter_pulse) state_d = WAIT_B;
        WAIT_B:  if (enter_pulse) state_d = WAIT_OP;
        WAIT_OP: if (enter_pulse) state_d = EXEC;
        EXEC:    state_d = SHOW;
        SHOW:    if (enter_pulse) state_d = WAIT_A;
        default: state_d = WAIT_A;
      endcase
    end
  end

  // Strobes are decoded here and registered so they line up with the captured value.
  always_comb begin
    cap_a  = !clear && enter_pulse && (state_q == WAIT_A);
    cap_b  = !clear && enter_pulse && (state_q == WAIT_B);
    cap_op = !clear && enter_pulse && (state_q == WAIT_OP);
    exec_d = !clear && (state_q == EXEC);
    stage  = state_q;
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      operand_a <= '0;
      operand_b <= '0;
      opcode    <= '0;
      load_a    <= 1'b0;
      load_b    <= 1'b0;
      load_op   <= 1'b0;
      execute   <= 1'b0;
    end else begin
      if (cap_a)  operand_a <= data_in;
      if (cap_b)  operand_b <= data_in;
      if (cap_op) opcode    <= data_in[OP_W-1:0];
      load_a  <= cap_a;
      load_b  <= cap_b;
      load_op <= cap_op;
      execute <= exec_d;
    end
  end
endmodule

// File: tb/tb_ula_input_sequencer.sv
// Directed bench for ula_input_sequencer (default build, no debounce).
module tb_ula_input_sequencer;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] data_in = '0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] operand_a, operand_b;
  logic [2:0] opcode;
  logic       load_a, load_b, load_op, execute;
  logic [2:0] stage;

  int checks = 0;
  int errors = 0;

  ula_input_sequencer #(.DATA_W(4), .OP_W(3), .DEBOUNCE_CYCLES(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in),
    .enter     (enter),
    .clear     (clear),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .opcode    (opcode),
    .load_a    (load_a),
    .load_b    (load_b),
    .load_op   (load_op),
    .execute   (execute),
    .stage     (stage)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] din;
    int stg;
    int a, b, op;
    int ld;   // {load_a, load_b, load_op}
    int ex;   // execute one cycle after the capture
    int stg2; // stage one cycle after the capture
  } vec_t;

  vec_t vt[7];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Raise enter, wait until the FSM has acted (two edges after first sample).
  task automatic press(input logic [3:0] d);
    data_in = d;
    enter = 1'b1;
    step();
    step();
    step();
  endtask

  task automatic release_btn();
    enter = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stage"}, stage, 0);
    chk({tag, "_a"}, operand_a, 0);
    chk({tag, "_b"}, operand_b, 0);
    chk({tag, "_op"}, opcode, 0);
    chk({tag, "_strobes"}, {load_a, load_b, load_op, execute}, 0);
  endtask

  initial begin
    int na;
    vt[0] = '{4'h5, 1, 5, 0, 0, 4, 0, 1};
    vt[1] = '{4'h3, 2, 5, 3, 0, 2, 0, 2};
    vt[2] = '{4'h2, 3, 5, 3, 2, 1, 1, 4};
    vt[3] = '{4'hA, 0, 5, 3, 2, 0, 0, 0};
    vt[4] = '{4'hA, 1, 10, 3, 2, 4, 0, 1};
    vt[5] = '{4'hF, 2, 10, 15, 2, 2, 0, 2};
    vt[6] = '{4'hE, 3, 10, 15, 6, 1, 1, 4};

    do_reset();
    chk_all_zero("reset");

    // Table-driven: two full sequences with SHOW -> WAIT_A in between.
    for (int i = 0; i < 7; i++) begin
      press(vt[i].din);
      chk($sformatf("v%0d_stage", i), stage, vt[i].stg);
      chk($sformatf("v%0d_a", i), operand_a, vt[i].a);
      chk($sformatf("v%0d_b", i), operand_b, vt[i].b);
      chk($sformatf("v%0d_op", i), opcode, vt[i].op);
      chk($sformatf("v%0d_ld", i), {load_a, load_b, load_op}, vt[i].ld);
      chk($sformatf("v%0d_exec0", i), execute, 0);
      step();
      chk($sformatf("v%0d_exec", i), execute, vt[i].ex);
      chk($sformatf("v%0d_ld_drop", i), {load_a, load_b, load_op}, 0);
      chk($sformatf("v%0d_stage2", i), stage, vt[i].stg2);
      release_btn();
      chk($sformatf("v%0d_exec_drop", i), execute, 0);
    end

    // Latency plus held button: load_a only after the second edge, then never again.
    do_reset();
    data_in = 4'h7;
    enter = 1'b1;
    step();
    chk("lat_k", load_a, 0);
    step();
    chk("lat_k1", load_a, 0);
    step();
    chk("lat_k2", load_a, 1);
    chk("lat_a", operand_a, 7);
    na = 1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (load_a) na++;
    end
    chk("held_loads", na, 1);
    chk("held_stage", stage, 1);
    release_btn();

    // Clear in the same cycle as the WAIT_OP enter pulse.
    do_reset();
    press(4'h5); release_btn();
    press(4'h3); release_btn();
    chk("clr_pre_stage", stage, 2);
    data_in = 4'h2;
    enter = 1'b1;
    step();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_all_zero("clr");
    step();
    chk("clr_no_exec", execute, 0);
    chk("clr_stay", stage, 0);
    release_btn();
    chk("clr_idle", stage, 0);

    // Clear while in EXEC suppresses execute.
    press(4'h4); release_btn();
    press(4'h1); release_btn();
    press(4'h3);
    chk("cex_stage", stage, 3);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_all_zero("cex");
    release_btn();

    // Reset while in EXEC, then a clean sequence.
    press(4'h9); release_btn();
    press(4'h8); release_btn();
    press(4'h6);
    chk("rex_stage", stage, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all_zero("rex");
    enter = 1'b0;
    step();
    step();
    press(4'h1); release_btn();
    press(4'h2); release_btn();
    press(4'h3);
    chk("post_a", operand_a, 1);
    chk("post_b", operand_b, 2);
    chk("post_op", opcode, 3);
    step();
    chk("post_exec", execute, 1);
    chk("post_stage", stage, 4);
    release_btn();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
